// File: rtl/countdown_timer.sv
// countdown_timer: loadable prescaled down-counter with pause/abort and a one-cycle done pulse.
// Define COUNTDOWN_TIMER_SVA_EN to compile the built-in assertions and covers.
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_vld,
  output logic             load_rdy,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic done_nx, tick;
  assign load_rdy = state == IDLE;
  assign busy     = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pre   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      pre   <= pre_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  // HOLD with pause released behaves exactly like RUN, so resuming costs no extra cycle
  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    tick     = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      pre_nx   = '0;
      cnt_nx   = '0;
    end else if (state == IDLE) begin
      if (load_vld) begin
        cnt_nx   = load_val;
        pre_nx   = '0;
        state_nx = load_val != '0 ? RUN : IDLE;
        done_nx  = load_val == '0;
      end
    end else if (pause) begin
      state_nx = HOLD;
    end else begin
      state_nx = RUN;
      tick     = pre == PW'(PRESCALE - 1);
      pre_nx   = tick ? '0 : pre + PW'(1);
      if (tick) begin
        cnt_nx = cnt - WIDTH'(1);
        if (cnt == WIDTH'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
    end
  end
`ifdef COUNTDOWN_TIMER_SVA_EN
  property p_run_step;
    @(posedge clk) disable iff (!rst_n)
      (state == RUN && $past(state) != IDLE) |-> (cnt == $past(cnt) || cnt == $past(cnt) - WIDTH'(1));
  endproperty
  property p_done_idle;
    @(posedge clk) disable iff (!rst_n) done |-> (cnt == '0 && state == IDLE);
  endproperty
  property p_done_single;
    @(posedge clk) disable iff (!rst_n) done |=> !done;
  endproperty
  property p_no_x;
    @(posedge clk) disable iff (!rst_n) !$isunknown({cnt, done, busy, load_rdy});
  endproperty
  property p_reset_cnt;
    @(posedge clk) !rst_n |=> cnt == '0;
  endproperty
  property p_abort_no_done;
    @(posedge clk) disable iff (!rst_n) abort |=> !done;
  endproperty
  a_run_step:      assert property (p_run_step)      else $error("a_run_step : FAIL");
  a_done_idle:     assert property (p_done_idle)     else $error("a_done_idle : FAIL");
  a_done_single:   assert property (p_done_single)   else $error("a_done_single : FAIL");
  a_no_x:          assert property (p_no_x)          else $error("a_no_x : FAIL");
  a_reset_cnt:     assert property (p_reset_cnt)     else $error("a_reset_cnt : FAIL");
  a_abort_no_done: assert property (p_abort_no_done) else $error("a_abort_no_done : FAIL");
  c_run_step:      cover property (p_run_step);
  c_done_idle:     cover property (p_done_idle);
  c_done_single:   cover property (p_done_single);
  c_no_x:          cover property (p_no_x);
  c_reset_cnt:     cover property (p_reset_cnt);
  c_abort_no_done: cover property (p_abort_no_done);
`endif
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of two timer instances, PRESCALE=1 and PRESCALE=3, on shared inputs.
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_vld = 1'b0;
  logic [7:0] load_val = '0;
  logic pause = 1'b0;
  logic abort = 1'b0;
  logic rdy1, busy1, done1, rdy3, busy3, done3;
  logic [7:0] cnt1, cnt3;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  countdown_timer #(.WIDTH(8), .PRESCALE(1)) u_ps1 (
    .clk(clk), .rst_n(rst_n), .load_vld(load_vld), .load_rdy(rdy1), .load_val(load_val),
    .pause(pause), .abort(abort), .cnt(cnt1), .busy(busy1), .done(done1));
  countdown_timer #(.WIDTH(8), .PRESCALE(3)) u_ps3 (
    .clk(clk), .rst_n(rst_n), .load_vld(load_vld), .load_rdy(rdy3), .load_val(load_val),
    .pause(pause), .abort(abort), .cnt(cnt3), .busy(busy3), .done(done3));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] v);
    load_vld = 1'b1;
    load_val = v;
    step;
    load_vld = 1'b0;
  endtask
  task automatic wait_idle;
    int n = 0;
    while ((busy1 || busy3) && n < 400) begin
      step;
      n++;
    end
    chk("idle_timeout", 32'(n < 400), 32'd1);
    step;
  endtask
  initial begin
    step;
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_rdy", 32'(rdy1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    rst_n = 1'b1;
    step;
    step;
    // PRESCALE=1, load 5
    load(8'd5);
    chk("p1_cnt0", 32'(cnt1), 32'd5);
    chk("p1_rdy0", 32'(rdy1), 32'd0);
    chk("p1_busy0", 32'(busy1), 32'd1);
    chk("p1_done0", 32'(done1), 32'd0);
    for (int i = 4; i >= 1; i--) begin
      step;
      chk("p1_cnt", 32'(cnt1), 32'(i));
      chk("p1_rdy", 32'(rdy1), 32'd0);
      chk("p1_done", 32'(done1), 32'd0);
    end
    step;
    chk("p1_cnt_end", 32'(cnt1), 32'd0);
    chk("p1_done_end", 32'(done1), 32'd1);
    chk("p1_rdy_end", 32'(rdy1), 32'd1);
    chk("p1_busy_end", 32'(busy1), 32'd0);
    step;
    chk("p1_done_drop", 32'(done1), 32'd0);
    wait_idle;
    // PRESCALE=3, load 2
    load(8'd2);
    chk("p3_cnt0", 32'(cnt3), 32'd2);
    chk("p3_busy0", 32'(busy3), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step;
      chk("p3_cnt", 32'(cnt3), k < 3 ? 32'd2 : k < 6 ? 32'd1 : 32'd0);
      chk("p3_busy", 32'(busy3), 32'(k < 6));
      chk("p3_done", 32'(done3), 32'(k == 6));
    end
    step;
    chk("p3_done_drop", 32'(done3), 32'd0);
    wait_idle;
    // zero-length load
    load(8'd0);
    chk("z_done1", 32'(done1), 32'd1);
    chk("z_done3", 32'(done3), 32'd1);
    chk("z_busy", 32'(busy1), 32'd0);
    chk("z_cnt", 32'(cnt1), 32'd0);
    step;
    chk("z_done_drop", 32'(done1), 32'd0);
    chk("z_busy_after", 32'(busy1), 32'd0);
    // pause for 4 cycles at cnt 7
    load(8'd10);
    repeat (3) step;
    chk("ps_cnt7", 32'(cnt1), 32'd7);
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("ps_hold_cnt", 32'(cnt1), 32'd7);
      chk("ps_hold_busy", 32'(busy1), 32'd1);
    end
    pause = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step;
      chk("ps_resume_cnt", 32'(cnt1), 32'(7 - k));
      chk("ps_resume_done", 32'(done1), 32'(k == 7));
    end
    wait_idle;
    // abort mid-count, then abort colliding with a load in IDLE
    load(8'd200);
    repeat (50) step;
    chk("ab_cnt150", 32'(cnt1), 32'd150);
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("ab_cnt", 32'(cnt1), 32'd0);
    chk("ab_busy", 32'(busy1), 32'd0);
    chk("ab_busy3", 32'(busy3), 32'd0);
    chk("ab_done", 32'(done1), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step;
      chk("ab_no_done", 32'({done1, done3}), 32'd0);
    end
    load_vld = 1'b1;
    load_val = 8'd9;
    abort = 1'b1;
    step;
    load_vld = 1'b0;
    abort = 1'b0;
    chk("abld_cnt", 32'(cnt1), 32'd0);
    chk("abld_rdy", 32'(rdy1), 32'd1);
    chk("abld_busy", 32'(busy1), 32'd0);
    chk("abld_done", 32'(done1), 32'd0);
    load(8'd3);
    chk("rl_cnt0", 32'(cnt1), 32'd3);
    for (int k = 1; k <= 3; k++) begin
      step;
      chk("rl_cnt", 32'(cnt1), 32'(3 - k));
      chk("rl_done", 32'(done1), 32'(k == 3));
    end
    wait_idle;
    // asynchronous reset mid-count
    load(8'd255);
    repeat (20) step;
    chk("ar_cnt235", 32'(cnt1), 32'd235);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt", 32'(cnt1), 32'd0);
    chk("ar_busy", 32'(busy1), 32'd0);
    chk("ar_done", 32'(done1), 32'd0);
    chk("ar_rdy", 32'(rdy1), 32'd1);
    chk("ar_cnt3", 32'(cnt3), 32'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("ar_stay_idle", 32'({busy1, done1, cnt1}), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter, the decrementing counterpart of the free-running up-counter in the same test area.
- Accepts a start value over a valid/ready handshake, counts down to zero at a prescaled rate, then pulses done.
- Supports pause and abort.
- Used as a timeout/delay generator by neighbouring blocks and as an SVA exercise target.

Parameters:
- WIDTH, 8, width of load value and count.
- PRESCALE, 1, clock cycles per decrement; legal range >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- load_vld  input  1  start value offered.
- load_rdy  output  1  block accepts a start value.
- load_val  input  WIDTH  start value; sampled on handshake.
- pause  input  1  level; freezes count while high.
- abort  input  1  one-cycle request; cancels the current count.
- cnt  output  WIDTH  current remaining count.
- busy  output  1  high while counting or paused.
- done  output  1  one-cycle pulse when the count expires.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, cnt=0, done=0, prescaler=0.
  - load_rdy=1 and busy=0 as combinational decodes of IDLE.
- All outputs except load_rdy and busy are registered.
- FSM states: IDLE, RUN, HOLD.
  - load_rdy = (state==IDLE).
  - busy = (state!=IDLE).
- IDLE:
  - On load_vld & load_rdy: cnt<=load_val; prescaler<=0.
  - If load_val!=0, go to RUN.
  - If load_val==0, stay IDLE and assert done for one cycle on the next edge (zero-length timer).
- RUN:
  - Prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and issues a tick; the tick causes cnt<=cnt-1.
  - When a tick occurs with cnt==1: cnt<=0, done<=1 (same edge), go to IDLE.
  - Latency: handshake at edge N gives cnt=load_val after N. cnt=0 and done=1 after edge N+load_val*PRESCALE.
  - cnt never wraps below 0. A decrement from 0 is illegal (asserted, see feature).
- HOLD:
  - pause high in RUN moves to HOLD on the next edge. That edge applies no tick; prescaler and cnt are frozen.
  - pause low in HOLD returns to RUN; the prescaler resumes from its frozen value.
  - pause in IDLE has no effect.
- abort, from any state: next edge goes to IDLE, cnt<=0, prescaler<=0, done stays 0.
- Priority: abort > pause > tick.
- abort with load_vld in IDLE: the load is ignored; load_rdy stays 1 and the value is not captured.
- done is high for exactly one cycle per expiry and never high while busy=1.
- A new load is accepted no earlier than the cycle after done (state is IDLE then).
- Reset asserted mid-RUN/HOLD: immediate return to reset values; no done.
- X-free outputs are required after the first clock following reset release.

Optional Feature:
- Macro: COUNTDOWN_TIMER_SVA_EN.
- When defined, the block contains concurrent assertions, each with a matching cover. All assertions are clocked on clk and disabled while rst_n is low, except the reset check:
  - in RUN, cnt == $past(cnt) or $past(cnt)-1;
  - done implies cnt==0 and state IDLE;
  - done is never high two consecutive cycles;
  - !$isunknown of cnt/done/busy/load_rdy;
  - !rst_n |=> cnt==0;
  - a past abort implies !done.
- Failures print "<label> : FAIL".
- When undefined: no assertion or cover code is compiled; RTL behaviour is identical.

Test Plan:
- WIDTH=8, PRESCALE=1: load 5 at edge 0 -> cnt 5,4,3,2,1,0 on edges 0..5; done=1 only after edge 5; load_rdy=0 edges 0..4, 1 after edge 5.
- PRESCALE=3: load 2 -> cnt holds 2 for 3 cycles, 1 for 3 cycles, then 0 with done after edge 6; busy high 6 cycles.
- Load 0 -> no RUN; done pulses once the next cycle; busy stays 0.
- Load 10, PRESCALE=1, pause high after cnt=7 for 4 cycles -> cnt stays 7 during HOLD; resumes; done 4 cycles later than without pause.
- Load 200, abort when cnt=150 -> next cycle cnt=0, busy=0, done never asserts; a following load 3 completes normally.
- Load 255, drop rst_n asynchronously mid-count -> cnt=0, busy=0, done=0 immediately. With COUNTDOWN_TIMER_SVA_EN defined, no assertion fires and all covers hit across the run.
